sram_mem_responder: RTL and testbench
=====================================

// Module: sram_mem_responder
// PURPOSE
//  Responder end of the MEM-stage data-memory interface. Serves 32-bit word
//  read/write requests issued by the pipeline's MEM stage (rd_en/wr_en,
//  ALU-result address, Rm write data) against an external 16-bit SRAM.
//  Each word is split into two half-word SRAM accesses.
//  ready is deasserted while an access is in flight; the top level freezes
//  all pipeline registers while ready=0.
// PARAMETERS
//  ADDR_BASE    1024  byte address mapped to SRAM word 0
//  SRAM_ADDR_W  18    SRAM half-word address width
//  PHASE_CYCLES 3     cycles per half-word access, >=2
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            synchronous reset, active-high
//  rd_en        in   1            MEM-stage read request
//  wr_en        in   1            MEM-stage write request
//  address      in   32           byte address (ALU result)
//  write_data   in   32           store data (Rm value)
//  read_data    out  32           load data to MEM/WB register
//  ready        out  1            0 = access in flight, freeze pipeline
//  sram_addr    out  SRAM_ADDR_W  half-word address
//  sram_dq_out  out  16           SRAM write data
//  sram_dq_oe   out  1            1 = drive sram_dq_out onto bus
//  sram_dq_in   in   16           SRAM read data
//  sram_we_n    out  1            SRAM write strobe, active-low
// BEHAVIOUR
//  - Reset values: state IDLE, read_data=0, sram_addr=0, sram_dq_out=0,
//    sram_dq_oe=0, sram_we_n=1. ready=1 after reset when no request is present.
//  - Word index = (address - ADDR_BASE) >> 2, computed in 32 bits. Any wrap
//    below ADDR_BASE is modulo 2^32; no error is flagged. The low half uses
//    sram_addr = {idx[SRAM_ADDR_W-2:0],1'b0}. The high half uses
//    {idx[SRAM_ADDR_W-2:0],1'b1}.
//  - FSM IDLE -> LO -> HI -> DONE -> IDLE. Phase counter runs 1..PHASE_CYCLES
//    in LO and in HI.
//  - IDLE: on rd_en|wr_en, latch address, write_data and op, then go to LO.
//    If both rd_en and wr_en are set, the op is a write.
//  - ready is combinational: ready = (IDLE & ~rd_en & ~wr_en) | DONE.
//    It falls in the same cycle the request appears.
//  - LO/HI write: sram_dq_oe=1. sram_dq_out = wdata[15:0] in LO, [31:16] in HI.
//    sram_we_n=0 on phase cycles 1..P-1 and 1 on cycle P (data hold).
//  - LO/HI read: sram_dq_oe=0, sram_we_n=1. On phase cycle P, sample
//    sram_dq_in into read_data[15:0] (LO) or read_data[31:16] (HI).
//  - DONE: one cycle with ready=1, then unconditionally back to IDLE. A
//    request present in the following IDLE cycle starts a new access.
//  - Latency: request seen in IDLE at cycle 0; DONE at cycle 2*P+1. With the
//    default P=3, the freeze lasts 7 cycles.
//  - read_data changes only during read phases and holds otherwise. Writes
//    never alter read_data.
//  - Request inputs are ignored outside IDLE. Only the latched copy is used.
//  - rst in any state returns to IDLE in the next cycle with the reset values
//    above. The in-flight access is abandoned and a partial write may remain
//    in SRAM.
// TESTING
//  - Reset: assert rst for 2 cycles -> ready=1, sram_we_n=1, sram_dq_oe=0,
//    read_data=0.
//  - Write: wr_en, address=1024, write_data=32'hDEAD_BEEF -> sram_addr=0 with
//    dq=16'hBEEF, then sram_addr=1 with dq=16'hDEAD. we_n pattern 0,0,1 per
//    phase; ready=0 for 7 cycles, then high in DONE.
//  - Read: rd_en, address=1028, SRAM model holds [2]=16'h5678 and
//    [3]=16'h1234 -> read_data=32'h1234_5678 in DONE; sram_dq_oe=0 throughout.
//  - Simultaneous rd_en & wr_en, address=1032, write_data=1 -> write to
//    sram_addr 4 and 5; read_data unchanged.
//  - Back-to-back: hold rd_en through DONE -> IDLE cycle (ready=0), then a
//    second 7-cycle access. The address change during LO is ignored.
//  - Reset mid-write (in HI, cycle 2) -> next cycle IDLE, we_n=1, oe=0,
//    read_data=0.

Source files
------------

// File: rtl/sram_mem_responder.sv
// ---------------------------------------------------------------------------
// sram_mem_responder
//
// Responder for the MEM-stage data-memory interface. A 32-bit word access
// from the pipeline is served as two half-word accesses on an external
// 16-bit SRAM (low half first, then high half). While an access is in flight
// `ready` is low and the pipeline holds all of its registers.
//
// Parameters
//   ADDR_BASE    byte address that maps to SRAM word 0
//   SRAM_ADDR_W  SRAM half-word address width
//   PHASE_CYCLES cycles spent on each half-word access (>= 2)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   rd_en        MEM-stage read request
//   wr_en        MEM-stage write request (wins when both are set)
//   address      byte address (ALU result)
//   write_data   store data (Rm value)
//   read_data    load data to the MEM/WB register
//   ready        0 = access in flight, pipeline must freeze
//   sram_addr    SRAM half-word address
//   sram_dq_out  SRAM write data
//   sram_dq_oe   1 = drive sram_dq_out onto the SRAM data bus
//   sram_dq_in   SRAM read data
//   sram_we_n    SRAM write strobe, active-low
// ---------------------------------------------------------------------------
module sram_mem_responder #(
  parameter logic [31:0] ADDR_BASE    = 32'd1024,
  parameter int          SRAM_ADDR_W  = 18,
  parameter int          PHASE_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);

  // Phase counter runs 1..PHASE_CYCLES, so it needs room for PHASE_CYCLES.
  localparam int              PW       = $clog2(PHASE_CYCLES + 1);
  localparam logic [PW-1:0]   PH_FIRST = PW'(1);
  localparam logic [PW-1:0]   PH_LAST  = PW'(PHASE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [PW-1:0]          r_phase;
  logic [PW-1:0]          w_phase_next;

  logic [31:0]            r_addr;
  logic [31:0]            r_wdata;
  logic [31:0]            r_rdata;
  logic                   r_is_wr;

  logic                   w_req;
  logic                   w_last_phase;
  logic [31:0]            w_offset;
  logic [SRAM_ADDR_W-2:0] w_half_base;
  logic                   w_unused_offset_bits;

  assign w_req        = rd_en | wr_en;
  assign w_last_phase = (r_phase == PH_LAST);

  // Byte offset from the window base; wraps modulo 2^32 when the address
  // lies below ADDR_BASE, which is intentionally not flagged.
  assign w_offset    = r_addr - ADDR_BASE;
  // Word index is offset >> 2; each word occupies two half-word slots.
  assign w_half_base = w_offset[SRAM_ADDR_W:2];
  // Byte-lane bits and index bits beyond the SRAM size play no part.
  assign w_unused_offset_bits = ^{w_offset[31:SRAM_ADDR_W+1], w_offset[1:0]};

  assign read_data = r_rdata;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= PH_FIRST;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and SRAM-side outputs
  // -------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    ready        = 1'b0;
    sram_addr    = '0;
    sram_dq_out  = '0;
    sram_dq_oe   = 1'b0;
    sram_we_n    = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        // ready drops in the same cycle a request shows up.
        ready        = ~w_req;
        w_phase_next = PH_FIRST;
        if (w_req) begin
          w_state_next = S_LO;
        end
      end

      S_LO: begin
        sram_addr   = {w_half_base, 1'b0};
        sram_dq_oe  = r_is_wr;
        sram_dq_out = r_is_wr ? r_wdata[15:0] : 16'h0000;
        // Strobe low for all but the last phase cycle, which holds data
        // on the bus after the rising edge of we_n.
        sram_we_n   = ~(r_is_wr & ~w_last_phase);
        if (w_last_phase) begin
          w_state_next = S_HI;
          w_phase_next = PH_FIRST;
        end else begin
          w_phase_next = r_phase + PW'(1);
        end
      end

      S_HI: begin
        sram_addr   = {w_half_base, 1'b1};
        sram_dq_oe  = r_is_wr;
        sram_dq_out = r_is_wr ? r_wdata[31:16] : 16'h0000;
        sram_we_n   = ~(r_is_wr & ~w_last_phase);
        if (w_last_phase) begin
          w_state_next = S_DONE;
          w_phase_next = PH_FIRST;
        end else begin
          w_phase_next = r_phase + PW'(1);
        end
      end

      S_DONE: begin
        // One release cycle; any request arriving now is taken up by IDLE.
        ready        = 1'b1;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Request capture and load-data assembly
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
      r_rdata <= '0;
    end else begin
      // Inputs are only looked at in IDLE; later changes are ignored.
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= address;
        r_wdata <= write_data;
        r_is_wr <= wr_en;
      end

      // Sample the SRAM on the last phase cycle, after the address has
      // been stable for the whole phase. Writes leave read_data alone.
      if (!r_is_wr && w_last_phase) begin
        if (r_state == S_LO) begin
          r_rdata[15:0] <= sram_dq_in;
        end else if (r_state == S_HI) begin
          r_rdata[31:16] <= sram_dq_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_mem_responder
//
// Drives word accesses into sram_mem_responder against a small behavioural
// 16-bit SRAM. Expected half-word writes and expected load words are queued
// when a request is issued and consumed when the responder performs them.
// ---------------------------------------------------------------------------
module tb_sram_mem_responder;

  localparam int SAW = 18;
  localparam int P   = 3;

  typedef struct {
    logic [SAW-1:0] addr;
    logic [15:0]    data;
  } wr_exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rd_en = 1'b0;
  logic           wr_en = 1'b0;
  logic [31:0]    address = '0;
  logic [31:0]    write_data = '0;
  logic [31:0]    read_data;
  logic           ready;
  logic [SAW-1:0] sram_addr;
  logic [15:0]    sram_dq_out;
  logic           sram_dq_oe;
  logic [15:0]    sram_dq_in;
  logic           sram_we_n;

  int n_checks = 0;
  int n_errors = 0;

  wr_exp_t     wq[$];
  logic [31:0] rq[$];
  logic [31:0] exp_rdata = '0;

  // Behavioural SRAM, 256 half-words, aliased on the low address bits.
  logic [15:0] mem [256] = '{default: 16'h0000};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      mem[2] <= 16'h5678;
      mem[3] <= 16'h1234;
    end else if (!sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq_out;
    end
  end

  assign sram_dq_in = mem[sram_addr[7:0]];

  sram_mem_responder #(
    .ADDR_BASE   (32'd1024),
    .SRAM_ADDR_W (SAW),
    .PHASE_CYCLES(P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One word access. keep_req holds rd_en high throughout (back-to-back);
  // abort_k > 0 asserts rst in that in-flight cycle.
  task automatic run_access(input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input bit keep_req, input int abort_k);
    logic [31:0]    idx;
    logic [SAW-1:0] a_lo;
    logic [SAW-1:0] a_hi;
    int             phase;
    bit             hi;
    bit             aborted;
    wr_exp_t        e;
    idx     = (addr - 32'd1024) >> 2;
    a_lo    = {idx[SAW-2:0], 1'b0};
    a_hi    = {idx[SAW-2:0], 1'b1};
    aborted = 1'b0;
    if (wr) begin
      wq.push_back('{a_lo, wdata[15:0]});
      wq.push_back('{a_hi, wdata[31:16]});
    end else begin
      rq.push_back({mem[a_hi[7:0]], mem[a_lo[7:0]]});
    end

    // Request cycle (IDLE).
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = addr; write_data = wdata;
    #1;
    check("req_ready", 32'(ready), 0);
    check("req_we_n", 32'(sram_we_n), 1);

    for (int k = 1; k <= 2 * P; k++) begin
      @(negedge clk);
      // Request inputs are scrambled in flight; the responder must ignore them.
      address    = $urandom;
      write_data = $urandom;
      if (keep_req) begin
        rd_en = 1'b1; wr_en = 1'b0;
      end else begin
        rd_en = 1'($urandom_range(0, 1));
        wr_en = 1'($urandom_range(0, 1));
      end
      if (k == abort_k) begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
      end
      #1;
      phase = ((k - 1) % P) + 1;
      hi    = (k > P);
      check("busy_ready", 32'(ready), 0);
      check("busy_oe", 32'(sram_dq_oe), 32'(wr));
      check("busy_we_n", 32'(sram_we_n), (wr && phase != P) ? 32'd0 : 32'd1);
      check("busy_addr", 32'(sram_addr), hi ? 32'(a_hi) : 32'(a_lo));
      if (wr) begin
        check("wq_nonempty", 32'(wq.size() != 0), 1);
        if (wq.size() != 0) begin
          check("wr_dq", 32'(sram_dq_out), 32'(wq[0].data));
          if (phase == P) begin
            e = wq.pop_front();
            check("wr_addr", 32'(sram_addr), 32'(e.addr));
          end
        end
      end
      if (k == abort_k) begin
        aborted = 1'b1;
        break;
      end
    end

    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      exp_rdata = '0;
      wq.delete();
      check("abort_ready", 32'(ready), 1);
      check("abort_we_n", 32'(sram_we_n), 1);
      check("abort_oe", 32'(sram_dq_oe), 0);
      check("abort_rdata", read_data, exp_rdata);
      check("abort_addr", 32'(sram_addr), 0);
      return;
    end

    // DONE cycle.
    @(negedge clk);
    address = $urandom;
    if (keep_req) begin
      rd_en = 1'b1; wr_en = 1'b0;
    end else begin
      rd_en = 1'b0; wr_en = 1'b0;
    end
    #1;
    check("done_ready", 32'(ready), 1);
    check("done_oe", 32'(sram_dq_oe), 0);
    check("done_we_n", 32'(sram_we_n), 1);
    if (!wr) begin
      check("rq_nonempty", 32'(rq.size() != 0), 1);
      if (rq.size() != 0) exp_rdata = rq.pop_front();
    end
    check("done_rdata", read_data, exp_rdata);
  endtask

  initial begin
    int sel;
    // Reset for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", 32'(ready), 1);
    check("rst_we_n", 32'(sram_we_n), 1);
    check("rst_oe", 32'(sram_dq_oe), 0);
    check("rst_rdata", read_data, 0);
    check("rst_addr", 32'(sram_addr), 0);
    check("rst_dq", 32'(sram_dq_out), 0);
    rst = 1'b0;

    // Plain write, then the written halves in the SRAM model.
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF, 1'b0, 0);
    check("mem0", 32'(mem[0]), 32'h0000_BEEF);
    check("mem1", 32'(mem[1]), 32'h0000_DEAD);

    // Read of preloaded word.
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 0);
    check("read_1028", read_data, 32'h1234_5678);

    // Read back what was written.
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 0);
    check("read_1024", read_data, 32'hDEAD_BEEF);

    // Simultaneous rd_en and wr_en is a write; read_data must hold.
    run_access(1'b1, 1'b1, 32'd1032, 32'h0000_0001, 1'b0, 0);
    check("both_rdata", read_data, 32'hDEAD_BEEF);
    check("mem4", 32'(mem[4]), 32'h0000_0001);
    check("mem5", 32'(mem[5]), 32'h0000_0000);

    // Back-to-back: rd_en held through DONE, next access starts in IDLE.
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, 0);
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 0);
    check("b2b_rdata", read_data, 32'h0000_0001);

    // Mixed random accesses inside the first few words.
    for (int n = 0; n < 8; n++) begin
      sel = $urandom_range(0, 2);
      run_access(sel != 1, sel != 0, 32'd1024 + 32'(4 * $urandom_range(0, 40)),
                 $urandom, 1'b0, 0);
    end

    // Address below the base wraps modulo 2^32.
    run_access(1'b0, 1'b1, 32'd0, 32'hCAFE_F00D, 1'b0, 0);

    // Reset during the second cycle of the high-half write.
    run_access(1'b0, 1'b1, 32'd1040, 32'hA5A5_5A5A, 1'b0, P + 2);

    // Responder works again after the abort.
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 0);
    check("post_abort_read", read_data, 32'h1234_5678);

    @(negedge clk);
    #1;
    check("final_idle_ready", 32'(ready), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
